mul_sched: RTL and testbench



---
 rtl/mul_sched_pkg.sv | 22 ++
 rtl/mul_sched_rr_arb.sv | 42 ++++
 rtl/mul_sched.sv | 149 ++++++++++++++
 tb/tb_mul_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// rtl/mul_sched_pkg.sv - shared types, defaults and helpers for mul_sched
//
// Purpose: FSM state encoding, default geometry and the index-width helper
//          used by mul_sched and mul_sched_rr_arb.
// Ports:   none (package).
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W    = 4;
  localparam int DEF_NREQ = 2;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_sched_rr_arb.sv
// rtl/mul_sched_rr_arb.sv - combinational round-robin grant for mul_sched
//
// Purpose: grants the first valid requester at or after the pointer,
//          wrapping, and supplies the pointer value that follows the grant.
// Ports:
//   req_valid_i  per-requester valid
//   ptr_i        current round-robin pointer (always < NREQ)
//   grant_o      one-hot grant, zero when nothing is valid
//   grant_idx_o  index of the granted requester (0 when none)
//   any_o        some requester is granted
//   next_ptr_o   (grant_idx_o + 1) mod NREQ
module mul_sched_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_o,
  output logic [IW-1:0]   next_ptr_o
);

  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    // Scan requesters in priority order starting at the pointer.
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid_i[(int'(ptr_i) + k) % NREQ]) begin
        found                                     = 1'b1;
        grant_o[(int'(ptr_i) + k) % NREQ]         = 1'b1;
        grant_idx_o                               = IW'((int'(ptr_i) + k) % NREQ);
      end
    end
    any_o      = found;
    next_ptr_o = (grant_idx_o == IW'(NREQ - 1)) ? '0 : grant_idx_o + IW'(1);
  end

endmodule

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - shared iterative shift-add multiplier for `a *= b`
//
// Purpose: NREQ requesters share one W x W shift-add multiplier through a
//          round-robin arbiter. Each request yields the truncated W-bit
//          product and the full 2W-bit product, unsigned or two's-complement.
// Optional: define MUL_SCHED_OVF_EN to add resp_ovf (truncation overflowed).
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready one-hot or zero)
//   req_a, req_b        operands, requester i at [i*W +: W]
//   req_signed          per-requester two's-complement select
//   resp_valid/ready    response handshake
//   resp_id             owning requester
//   resp_prod           truncated product (new value of a)
//   resp_full           full 2W-bit product
//   resp_ovf            (MUL_SCHED_OVF_EN only) resp_full != extended resp_prod
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  parameter int  W    = DEF_W,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_signed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IW-1:0]     resp_id,
  output logic [W-1:0]      resp_prod,
`ifdef MUL_SCHED_OVF_EN
  output logic              resp_ovf,
`endif
  output logic [2*W-1:0]    resp_full
);

  localparam int             ITW  = idx_width(W);
  localparam logic [ITW-1:0] LAST = ITW'(W - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [ITW-1:0]   iter_q, iter_d;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic [IW-1:0]    next_ptr;
  logic [2*W-1:0]   a_ext;
  logic [2*W-1:0]   term;

  mul_sched_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any),
    .next_ptr_o  (next_ptr)
  );

  // Grants are only offered while idle and out of reset.
  assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
  assign resp_valid = (state_q == DONE);
  assign resp_id    = id_q;
  assign resp_full  = acc_q;
  assign resp_prod  = acc_q[W-1:0];

`ifdef MUL_SCHED_OVF_EN
  logic [2*W-1:0] prod_ext;
  assign prod_ext = sgn_q ? {{W{acc_q[W-1]}}, acc_q[W-1:0]}
                          : {{W{1'b0}}, acc_q[W-1:0]};
  assign resp_ovf = (state_q == DONE) && (acc_q != prod_ext);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    a_ext   = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    term    = a_ext << iter_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          a_d     = req_a[int'(grant_idx)*W +: W];
          b_d     = req_b[int'(grant_idx)*W +: W];
          sgn_d   = req_signed[grant_idx];
          id_d    = grant_idx;
          acc_d   = '0;
          iter_d  = '0;
          ptr_d   = next_ptr;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q[iter_q]) begin
          // The MSB of a signed multiplier carries weight -2^(W-1).
          if (sgn_q && iter_q == LAST) acc_d = acc_q - term;
          else                         acc_d = acc_q + term;
        end
        iter_d = iter_q + ITW'(1);
        if (iter_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - directed self-checking bench for mul_sched
module tb_mul_sched;

  localparam int W    = 4;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_signed;
  logic              resp_valid;
  logic              resp_ready;
  logic [0:0]        resp_id;
  logic [W-1:0]      resp_prod;
  logic [2*W-1:0]    resp_full;
`ifdef MUL_SCHED_OVF_EN
  logic              resp_ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod),
`ifdef MUL_SCHED_OVF_EN
    .resp_ovf   (resp_ovf),
`endif
    .resp_full  (resp_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!resp_valid && n < 40) begin step(); n++; end
    check({tag, "_resp_timeout"}, 32'(n >= 40), 0);
  endtask

  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] ef, input logic [W-1:0] ep,
                         input logic eo, input string tag);
    int n = 0;
    int t;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_signed[idx]   = s;
    req_valid[idx]    = 1'b1;
    #1;
    while (!req_ready[idx] && n < 40) begin step(); n++; end
    check({tag, "_grant_timeout"}, 32'(n >= 40), 0);
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    t = cyc;
    step();
    req_valid[idx] = 1'b0;
    wait_resp(tag);
    check({tag, "_latency"}, 32'(cyc - t), W + 1);
    check({tag, "_id"}, 32'(resp_id), 32'(idx));
    check({tag, "_full"}, 32'(resp_full), 32'(ef));
    check({tag, "_prod"}, 32'(resp_prod), 32'(ep));
`ifdef MUL_SCHED_OVF_EN
    check({tag, "_ovf"}, 32'(resp_ovf), 32'(eo));
`else
    if (eo === 1'bx) check({tag, "_ovf_x"}, 32'(eo), 0);
`endif
    step();
    check({tag, "_drop"}, 32'(resp_valid), 0);
  endtask

  initial begin
    logic [2*W-1:0] held_full;
    logic [NREQ-1:0] g[4];
    int c[4];
    int k;
    int n;
    bit seen;

    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    resp_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_id",    32'(resp_id), 0);
    check("rst_full",  32'(resp_full), 0);
    check("rst_prod",  32'(resp_prod), 0);
    req_valid = '0;
    rst       = 1'b0;
    step();

    // Basic products; alternating requesters also exercise pointer wrap.
    run_one(0, 4'h7, 4'h9, 1'b0, 8'h3F, 4'hF, 1'b1, "u7x9");
    run_one(1, 4'hD, 4'h5, 1'b1, 8'hF1, 4'h1, 1'b1, "sDx5");
    run_one(0, 4'hD, 4'h5, 1'b0, 8'h41, 4'h1, 1'b1, "uDx5");
    run_one(1, 4'h8, 4'h8, 1'b1, 8'h40, 4'h0, 1'b1, "s8x8");
    run_one(0, 4'hF, 4'hF, 1'b1, 8'h01, 4'h1, 1'b0, "sFxF");
    run_one(1, 4'h5, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, "u5x0");

    // Backpressure: response held while resp_ready is low.
    resp_ready = 1'b0;
    req_a[0 +: W] = 4'h7; req_b[0 +: W] = 4'h9; req_signed[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 40) begin step(); n++; end
    check("bp_grant_timeout", 32'(n >= 40), 0);
    step();
    req_valid[0] = 1'b0;
    wait_resp("bp");
    held_full = resp_full;
    check("bp_full", 32'(held_full), 32'h3F);
    req_a[W +: W] = 4'h2; req_b[W +: W] = 4'h2; req_signed[1] = 1'b0;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", 32'(resp_valid), 1);
      check("bp_hold_full",  32'(resp_full), 32'(held_full));
      check("bp_hold_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(resp_valid), 0);
    check("bp_release_ready", 32'(req_ready), 32'h2);
    run_one(1, 4'h2, 4'h2, 1'b0, 8'h04, 4'h4, 1'b0, "bp_next");

    // Reset during CALC: no response, reset values, pointer back to 0.
    req_a[0 +: W] = 4'h5; req_b[0 +: W] = 4'h3; req_signed[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 40) begin step(); n++; end
    check("rc_grant_timeout", 32'(n >= 40), 0);
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rc_valid", 32'(resp_valid), 0);
    check("rc_full",  32'(resp_full), 0);
    check("rc_prod",  32'(resp_prod), 0);
    check("rc_id",    32'(resp_id), 0);
    check("rc_ready", 32'(req_ready), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid) seen = 1'b1;
    end
    check("rc_no_resp", 32'(seen), 0);

    // Round-robin with both requesters continuously valid.
    req_a = {4'h3, 4'h2};
    req_b = {4'h3, 4'h3};
    req_signed = '0;
    req_valid  = 2'b11;
    #1;
    k = 0;
    n = 0;
    while (k < 4 && n < 80) begin
      if (req_ready != '0) begin
        g[k] = req_ready;
        c[k] = cyc;
        k++;
      end
      if (resp_valid)
        check("rr_full", 32'(resp_full), (resp_id == 1'b0) ? 32'h06 : 32'h09);
      step();
      n++;
    end
    req_valid = '0;
    check("rr_timeout", 32'(k), 4);
    check("rr_g0", 32'(g[0]), 1);
    check("rr_g1", 32'(g[1]), 2);
    check("rr_g2", 32'(g[2]), 1);
    check("rr_g3", 32'(g[3]), 2);
    for (int i = 1; i < 4; i++) check("rr_interval", 32'(c[i] - c[i-1]), W + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
